// File: rtl/addsub_seq_pkg.sv
// Shared types and helpers for the word-serial add/subtract sequencer.
// The sequencer walks NWORDS words through one WIDTH-bit carry-chain slice.
package addsub_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // The index register needs at least one bit even for degenerate word counts
  function automatic int idx_width(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational WIDTH-bit add/subtract slice: ripple carry chain with optional
// inversion of the second operand, so subtraction is I0 + ~I1 + CIN.
module addsub_slice #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             SUB,
  input  logic             CIN,
  output logic [WIDTH-1:0] O,
  output logic             COUT
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   chain;

  always_comb begin
    b_eff    = SUB ? ~I1 : I1;
    chain    = '0;
    chain[0] = CIN;
    O        = '0;
    for (int i = 0; i < WIDTH; i++) begin
      O[i]         = I0[i] ^ b_eff[i] ^ chain[i];
      chain[i + 1] = (I0[i] & b_eff[i]) | (chain[i] & (I0[i] ^ b_eff[i]));
    end
    COUT = chain[WIDTH];
  end

endmodule

// File: rtl/addsub_seq.sv
// Word-serial add/subtract sequencer with valid/ready handshakes on both sides.
// Optional zero flag output Z is enabled by defining ADDSUB_SEQ_ZERO_FLAG_EN.
module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int NWORDS = 4
) (
  input  logic                CLK,
  input  logic                ASYNCRESET,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [WIDTH*NWORDS-1:0] I0,
  input  logic [WIDTH*NWORDS-1:0] I1,
  input  logic                SUB,
  input  logic                CIN,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [WIDTH*NWORDS-1:0] O,
  output logic                COUT
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
  ,
  output logic                Z
`endif
);

  localparam int N     = WIDTH * NWORDS;
  localparam int IDX_W = idx_width(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_t           state;
  logic [N-1:0]     a_sr;
  logic [N-1:0]     b_sr;
  logic [N-1:0]     res;
  logic             sub_r;
  logic             carry;
  logic             cout_r;
  logic [IDX_W-1:0] idx;

  logic [WIDTH-1:0] slice_o;
  logic             slice_cout;

`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
  logic zero_r;
`endif

  addsub_slice #(
    .WIDTH(WIDTH)
  ) u_slice (
    .I0  (a_sr[WIDTH-1:0]),
    .I1  (b_sr[WIDTH-1:0]),
    .SUB (sub_r),
    .CIN (carry),
    .O   (slice_o),
    .COUT(slice_cout)
  );

  // Operands shift right one word per RUN cycle so the slice always sees the
  // current word in the low bits; the result is written back by index.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state     <= IDLE;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      res       <= '0;
      sub_r     <= OP_ADD;
      carry     <= 1'b0;
      cout_r    <= 1'b0;
      idx       <= '0;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
      zero_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            a_sr     <= I0;
            b_sr     <= I1;
            sub_r    <= SUB;
            carry    <= (SUB == OP_SUB) ? ~CIN : CIN;
            idx      <= '0;
            IN_READY <= 1'b0;
            state    <= RUN;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
            zero_r   <= 1'b1;
`endif
          end
        end
        RUN: begin
          a_sr <= a_sr >> WIDTH;
          b_sr <= b_sr >> WIDTH;
          res[idx*WIDTH +: WIDTH] <= slice_o;
          carry <= slice_cout;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
          zero_r <= zero_r & ~(|slice_o);
`endif
          if (idx == LAST_IDX) begin
            idx       <= '0;
            cout_r    <= slice_cout;
            OUT_VALID <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          IN_READY  <= 1'b1;
          OUT_VALID <= 1'b0;
        end
      endcase
    end
  end

  assign O    = res;
  assign COUT = cout_r;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
  assign Z    = zero_r;
`endif

endmodule

// File: tb/tb_addsub_seq.sv
// Directed self-checking bench for addsub_seq at default parameters (N = 8).
// Edge counts are taken #1 after each rising edge; accept edge is latency edge 1.
module tb_addsub_seq;

  logic       CLK = 1'b0;
  logic       ASYNCRESET;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] I0;
  logic [7:0] I1;
  logic       SUB;
  logic       CIN;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] O;
  logic       COUT;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
  logic       Z;
`endif

  int checks = 0;
  int errors = 0;
  int edge_count = 0;
  int acc_edge;
  int acc_edge2;
  int ov_edge;
  logic ok;

  addsub_seq dut (
    .CLK       (CLK),
    .ASYNCRESET(ASYNCRESET),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .I0        (I0),
    .I1        (I1),
    .SUB       (SUB),
    .CIN       (CIN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .O         (O),
    .COUT      (COUT)
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
    ,
    .Z         (Z)
`endif
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_count <= edge_count + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic timeoutFail(input string tag);
    checks++;
    errors++;
    $error("[TB] FAIL %s observed=timeout expected=event within 20 cycles", tag);
  endtask

  // Presents operands, waits (bounded) for IN_READY, and returns the accept edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic s, input logic c, input logic hold_valid,
                               output int acc);
    int n;
    I0 = a; I1 = b; SUB = s; CIN = c; IN_VALID = 1'b1;
    n = 0;
    while (!IN_READY && n < 20) begin
      @(posedge CLK); #1; n++;
    end
    if (!IN_READY) timeoutFail("accept");
    @(posedge CLK); #1;
    acc = edge_count;
    if (!hold_valid) IN_VALID = 1'b0;
  endtask

  task automatic waitResult(output int ov);
    int n;
    n = 0;
    while (!OUT_VALID && n < 20) begin
      @(posedge CLK); #1; n++;
    end
    if (!OUT_VALID) timeoutFail("out_valid");
    ov = edge_count;
  endtask

  task automatic popResult();
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    checkOutput("pop_in_ready", 32'(IN_READY), 32'd1);
    checkOutput("pop_out_valid", 32'(OUT_VALID), 32'd0);
  endtask

  initial begin
    ASYNCRESET = 1'b1;
    IN_VALID = 1'b0; OUT_READY = 1'b0;
    I0 = '0; I1 = '0; SUB = 1'b0; CIN = 1'b0;
    #12;
    checkOutput("rst_in_ready", 32'(IN_READY), 32'd1);
    checkOutput("rst_out_valid", 32'(OUT_VALID), 32'd0);
    checkOutput("rst_o", 32'(O), 32'h00);
    checkOutput("rst_cout", 32'(COUT), 32'd0);
    @(posedge CLK); #1;
    ASYNCRESET = 1'b0;
    @(posedge CLK); #1;

    // 0x5A + 0x3C, latency: OUT_VALID seen 4 edges after the accept edge
    applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, acc_edge);
    waitResult(ov_edge);
    checkOutput("add_latency", 32'(ov_edge - acc_edge), 32'd4);
    checkOutput("add_o", 32'(O), 32'h96);
    checkOutput("add_cout", 32'(COUT), 32'd0);
    popResult();

    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, acc_edge);
    waitResult(ov_edge);
    checkOutput("wrap_o", 32'(O), 32'h00);
    checkOutput("wrap_cout", 32'(COUT), 32'd1);
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
    checkOutput("wrap_z", 32'(Z), 32'd1);
`endif
    popResult();

    applyStimulus(8'h10, 8'h01, 1'b1, 1'b0, 1'b0, acc_edge);
    waitResult(ov_edge);
    checkOutput("sub_o", 32'(O), 32'h0F);
    checkOutput("sub_cout", 32'(COUT), 32'd1);
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
    checkOutput("sub_z", 32'(Z), 32'd0);
`endif
    popResult();

    applyStimulus(8'h10, 8'h01, 1'b1, 1'b1, 1'b0, acc_edge);
    waitResult(ov_edge);
    checkOutput("subb_o", 32'(O), 32'h0E);
    checkOutput("subb_cout", 32'(COUT), 32'd1);
    popResult();

    applyStimulus(8'h00, 8'h01, 1'b1, 1'b0, 1'b0, acc_edge);
    waitResult(ov_edge);
    checkOutput("borrow_o", 32'(O), 32'hFF);
    checkOutput("borrow_cout", 32'(COUT), 32'd0);
    popResult();

    // Backpressure: result held, new operands offered during DONE are ignored
    applyStimulus(8'h81, 8'h82, 1'b0, 1'b0, 1'b0, acc_edge);
    waitResult(ov_edge);
    I0 = 8'h01; I1 = 8'h02; SUB = 1'b0; CIN = 1'b0; IN_VALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      checkOutput("bp_o", 32'(O), 32'h03);
      checkOutput("bp_cout", 32'(COUT), 32'd1);
      checkOutput("bp_in_ready", 32'(IN_READY), 32'd0);
      checkOutput("bp_out_valid", 32'(OUT_VALID), 32'd1);
    end
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    checkOutput("bp_release_in_ready", 32'(IN_READY), 32'd1);
    checkOutput("bp_release_out_valid", 32'(OUT_VALID), 32'd0);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    checkOutput("bp_next_accepted", 32'(IN_READY), 32'd0);
    waitResult(ov_edge);
    checkOutput("bp_next_o", 32'(O), 32'h03);
    checkOutput("bp_next_cout", 32'(COUT), 32'd0);
    popResult();

    // Reset during the second RUN cycle
    applyStimulus(8'hAA, 8'h55, 1'b0, 1'b0, 1'b0, acc_edge);
    @(posedge CLK); #1;
    ASYNCRESET = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(OUT_VALID), 32'd0);
    checkOutput("midrst_o", 32'(O), 32'h00);
    checkOutput("midrst_in_ready", 32'(IN_READY), 32'd1);
    checkOutput("midrst_cout", 32'(COUT), 32'd0);
    @(posedge CLK); #1;
    ASYNCRESET = 1'b0;
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, acc_edge);
    waitResult(ov_edge);
    checkOutput("postrst_latency", 32'(ov_edge - acc_edge), 32'd4);
    checkOutput("postrst_o", 32'(O), 32'h02);
    popResult();

    // Back-to-back with IN_VALID and OUT_READY held high
    OUT_READY = 1'b1;
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, acc_edge);
    I0 = 8'h70; I1 = 8'h30; SUB = 1'b1; CIN = 1'b0;
    waitResult(ov_edge);
    checkOutput("b2b_first_o", 32'(O), 32'h46);
    checkOutput("b2b_first_cout", 32'(COUT), 32'd0);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(posedge CLK); #1;
      if (IN_READY) ok = 1'b1;
    end
    if (!ok) timeoutFail("b2b_idle");
    @(posedge CLK); #1;
    acc_edge2 = edge_count;
    IN_VALID = 1'b0;
    checkOutput("b2b_second_accepted", 32'(IN_READY), 32'd0);
    checkOutput("b2b_accept_spacing", 32'(acc_edge2 - acc_edge), 32'd6);
    waitResult(ov_edge);
    checkOutput("b2b_second_o", 32'(O), 32'h40);
    checkOutput("b2b_second_cout", 32'(COUT), 32'd1);
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    checkOutput("b2b_end_in_ready", 32'(IN_READY), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
